// File: rtl/ssio_sdr_tx_arb_if.sv
// rtl/ssio_sdr_tx_arb_if.sv - requester stream bundle feeding ssio_sdr_tx_arb
interface ssio_sdr_tx_arb_if #(
    parameter int WIDTH = 8,
    parameter int PORTS = 3
);
    logic [PORTS*WIDTH-1:0] s_data;
    logic [PORTS-1:0]       s_valid;
    logic [PORTS-1:0]       s_last;
    logic [PORTS-1:0]       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/ssio_sdr_tx_arb.sv
// rtl/ssio_sdr_tx_arb.sv - round-robin frame arbiter for one SDR TX lane
// Optional underrun/error signalling enabled by SSIO_TX_ARB_UNDERRUN_EN.
module ssio_sdr_tx_arb #(
    parameter int               WIDTH      = 8,
    parameter int               PORTS      = 3,
    parameter int               IFG_CYCLES = 12,
    parameter logic [WIDTH-1:0] IDLE_DATA  = '0,
    localparam int              GW         = (PORTS > 2) ? $clog2(PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ssio_sdr_tx_arb_if.slave     req,
    output logic [WIDTH-1:0]     out_d,
    output logic                 out_en,
    output logic                 out_er,
    output logic                 busy,
    output logic [GW-1:0]        grant_idx,
    output logic                 underrun
);

    localparam int CW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     gap_cnt;
    logic [CW-1:0]     gap_nxt;
    logic [GW-1:0]     grant_nxt;
    logic [GW-1:0]     last_ptr;
    logic [GW-1:0]     last_nxt;
    logic [GW-1:0]     rr_idx [PORTS];
    logic [GW-1:0]     rr_pick;
    logic              rr_found;
    logic              sel_valid;
    logic              sel_last;
    logic [WIDTH-1:0]  sel_data;
    logic              accept;
    logic [PORTS-1:0]  ready_int;

    // Candidate order for the next grant: last+1, last+2, ... wrapping modulo PORTS.
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            rr_idx[k] = GW'((int'(last_ptr) + k + 1) % PORTS);
        end
    end

    always_comb begin
        rr_pick  = last_ptr;
        rr_found = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (!rr_found && req.s_valid[rr_idx[k]]) begin
                rr_pick  = rr_idx[k];
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_valid = req.s_valid[i];
                sel_last  = req.s_last[i];
                sel_data  = req.s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        grant_nxt = grant_idx;
        last_nxt  = last_ptr;
        accept    = 1'b0;
        ready_int = '0;
        unique case (state)
            S_IDLE: begin
                // Arbitration cycle: the grant is latched, no beat is taken yet.
                if (rr_found) begin
                    grant_nxt = rr_pick;
                    last_nxt  = rr_pick;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                for (int i = 0; i < PORTS; i++) begin
                    if (grant_idx == GW'(i)) begin
                        ready_int[i] = 1'b1;
                    end
                end
                if (sel_valid) begin
                    accept = 1'b1;
                    if (sel_last) begin
                        if (IFG_CYCLES == 0) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_GAP;
                            gap_nxt   = CW'(IFG_CYCLES - 1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign req.s_ready = ready_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            grant_idx <= '0;
            last_ptr  <= GW'(PORTS - 1);
            out_d     <= IDLE_DATA;
            out_en    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            grant_idx <= grant_nxt;
            last_ptr  <= last_nxt;
            out_d     <= accept ? sel_data : IDLE_DATA;
            out_en    <= accept;
            // Follows the state by one cycle so it lines up with out_en.
            busy      <= (state != S_IDLE);
        end
    end

`ifdef SSIO_TX_ARB_UNDERRUN_EN
    logic starve;

    assign starve = (state == S_ACTIVE) && !sel_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_er   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            out_er   <= starve;
            underrun <= starve;
        end
    end
`else
    assign out_er   = 1'b0;
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ssio_sdr_tx_arb.sv
// tb/tb_ssio_sdr_tx_arb.sv - scoreboard bench for ssio_sdr_tx_arb
module tb_ssio_sdr_tx_arb;

    localparam int WIDTH = 8;
    localparam int PORTS = 3;
    localparam int IFG   = 3;
    localparam int GW    = 2;
`ifdef SSIO_TX_ARB_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               last;
        int               stall;
    } beat_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               port;
        bit               first;
        bit               last;
        int               stall;
        int               spacing;
        bit               round_first;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ssio_sdr_tx_arb_if #(.WIDTH(WIDTH), .PORTS(PORTS)) req  ();
    ssio_sdr_tx_arb_if #(.WIDTH(WIDTH), .PORTS(PORTS)) req0 ();

    logic [WIDTH-1:0] out_d, out_d0;
    logic             out_en, out_en0, out_er, out_er0, busy, busy0, underrun, underrun0;
    logic [GW-1:0]    grant_idx, grant_idx0;

    ssio_sdr_tx_arb #(.WIDTH(WIDTH), .PORTS(PORTS), .IFG_CYCLES(IFG), .IDLE_DATA(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .out_d(out_d), .out_en(out_en), .out_er(out_er), .busy(busy),
        .grant_idx(grant_idx), .underrun(underrun)
    );

    ssio_sdr_tx_arb #(.WIDTH(WIDTH), .PORTS(PORTS), .IFG_CYCLES(0), .IDLE_DATA(8'h00)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n), .req(req0),
        .out_d(out_d0), .out_en(out_en0), .out_er(out_er0), .busy(busy0),
        .grant_idx(grant_idx0), .underrun(underrun0)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    beat_t pq [PORTS][$];
    exp_t  sb [$];
    int    model_last    = PORTS - 1;
    bit    mon_en        = 1'b0;
    int    round_start   = 0;
    int    last_beat_cyc = 0;
    int    idle_run      = 0;
    bit    in_frame      = 1'b0;
    exp_t  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_beat(input int p, input logic [WIDTH-1:0] d, input bit last, input int stall);
        beat_t b;
        b.d = d; b.last = last; b.stall = stall;
        pq[p].push_back(b);
    endtask

    task automatic add_frame(input int p, input int len, input int stall_max);
        for (int k = 0; k < len; k++) begin
            add_beat(p, WIDTH'($urandom), (k == len - 1), (k == 0) ? 0 : $urandom_range(0, stall_max));
        end
    endtask

    // Frame-level round-robin: every port with frames queued is requesting at each arbitration.
    task automatic build_model();
        int    pos [PORTS];
        int    p;
        bit    any;
        bit    fst;
        bit    rf;
        beat_t b;
        exp_t  e;
        rf = 1'b1;
        for (int i = 0; i < PORTS; i++) pos[i] = 0;
        while (1) begin
            any = 1'b0;
            p   = 0;
            for (int k = 1; k <= PORTS; k++) begin
                int c;
                c = (model_last + k) % PORTS;
                if (!any && pos[c] < pq[c].size()) begin
                    any = 1'b1;
                    p   = c;
                end
            end
            if (!any) break;
            model_last = p;
            fst = 1'b1;
            do begin
                b = pq[p][pos[p]];
                e.d = b.d; e.port = p; e.first = fst; e.last = b.last;
                e.stall = b.stall; e.spacing = IFG + 1; e.round_first = fst && rf;
                sb.push_back(e);
                pos[p]++;
                fst = 1'b0;
            end while (!b.last);
            rf = 1'b0;
        end
    endtask

    task automatic drive_port(input int p, input bit v, input logic [WIDTH-1:0] d, input bit l);
        req.s_valid[p]               = v;
        req.s_last[p]                = v & l;
        req.s_data[p*WIDTH +: WIDTH] = v ? d : '0;
    endtask

    task automatic run_round();
        bit acc [PORTS];
        int stall_left [PORTS];
        bit done;
        bit empty;
        build_model();
        for (int p = 0; p < PORTS; p++) begin
            acc[p] = 1'b0;
            stall_left[p] = 0;
        end
        done = 1'b0;
        @(negedge clk);
        round_start = cyc;
        for (int t = 0; t < 3000; t++) begin
            if (t > 0) @(negedge clk);
            empty = 1'b1;
            for (int p = 0; p < PORTS; p++) begin
                if (acc[p]) begin
                    void'(pq[p].pop_front());
                    stall_left[p] = (pq[p].size() > 0) ? pq[p][0].stall : 0;
                end
                if (pq[p].size() > 0) empty = 1'b0;
                if (pq[p].size() > 0 && stall_left[p] == 0) begin
                    drive_port(p, 1'b1, pq[p][0].d, pq[p][0].last);
                end else begin
                    drive_port(p, 1'b0, '0, 1'b0);
                    if (stall_left[p] > 0) stall_left[p]--;
                end
            end
            if (empty) begin
                done = 1'b1;
                break;
            end
            #1;
            for (int p = 0; p < PORTS; p++) acc[p] = req.s_valid[p] & req.s_ready[p];
        end
        if (!done) check("round_timeout", 32'd1, 32'd0);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check("busy_fall_delay", cyc - last_beat_cyc, IFG + 1);
        check("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("ready_onehot", 32'($countones(req.s_ready) <= 1), 32'd1);
            if (out_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {24'd0, out_d}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("data", out_d, mon_e.d);
                    check("grant_idx", grant_idx, mon_e.port);
                    if (mon_e.round_first)  check("first_latency", cyc - round_start, 2);
                    else if (mon_e.first)   check("ifg_spacing", idle_run, mon_e.spacing);
                    else                    check("underrun_len", idle_run, mon_e.stall);
                    in_frame      = !mon_e.last;
                    last_beat_cyc = cyc;
                end
                idle_run = 0;
            end else begin
                check("idle_data", out_d, 0);
                check("out_er", out_er, in_frame & UR_EN);
                check("underrun", underrun, in_frame & UR_EN);
                idle_run++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_en"}, out_en, 0);
        check({tag, "_out_d"}, out_d, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, req.s_ready, 0);
        check({tag, "_grant"}, grant_idx, 0);
        check({tag, "_out_er"}, out_er, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        logic       en_s [8];
        logic [7:0] d_s [8];
        logic [1:0] g_s [8];
        logic [7:0] c_beats [4];
        bit         a;
        int         sent;
        int         np;

        rst_n = 1'b0;
        req.s_valid = '0;  req.s_last = '0;  req.s_data = '0;
        req0.s_valid = '0; req0.s_last = '0; req0.s_data = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("post_reset");
        check("nogap_reset_en", out_en0, 0);

        // Zero-gap instance: back-to-back single-beat frames on port 2.
        a = 1'b0;
        sent = 0;
        for (int t = 0; t < 8; t++) begin
            if (t > 0) @(negedge clk);
            en_s[t] = out_en0; d_s[t] = out_d0; g_s[t] = grant_idx0;
            if (a) sent++;
            req0.s_valid = (sent < 2) ? 3'b100 : 3'b000;
            req0.s_last  = (sent < 2) ? 3'b100 : 3'b000;
            req0.s_data  = (sent == 0) ? {8'h5A, 16'h0} : (sent == 1) ? {8'h5B, 16'h0} : '0;
            #1;
            a = req0.s_valid[2] & req0.s_ready[2];
        end
        check("nogap_en_t1", en_s[1], 0);
        check("nogap_en_t2", en_s[2], 1);
        check("nogap_d_t2", d_s[2], 8'h5A);
        check("nogap_en_t3", en_s[3], 0);
        check("nogap_en_t4", en_s[4], 1);
        check("nogap_d_t4", d_s[4], 8'h5B);
        check("nogap_en_t5", en_s[5], 0);
        check("nogap_grant", {g_s[2], g_s[4]}, 4'b1010);

        mon_en = 1'b1;

        add_beat(0, 8'h11, 1'b0, 0);
        add_beat(0, 8'h22, 1'b0, 0);
        add_beat(0, 8'h33, 1'b1, 0);
        run_round();

        for (int p = 0; p < PORTS; p++) begin
            add_frame(p, 2, 0);
            add_frame(p, 2, 0);
        end
        run_round();

        add_beat(1, 8'hA0, 1'b0, 0);
        add_beat(1, 8'hA1, 1'b1, 2);
        run_round();

        for (int f = 0; f < 3; f++) add_frame(2, $urandom_range(1, 3), 1);
        run_round();

        for (int r = 0; r < 8; r++) begin
            np = 0;
            for (int p = 0; p < PORTS; p++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 5), 2);
                np += nf;
            end
            if (np == 0) add_frame($urandom_range(0, PORTS - 1), 1, 0);
            run_round();
        end

        // Reset during beat 2 of a 4-beat frame on port 0.
        mon_en = 1'b0;
        c_beats[0] = 8'hC1; c_beats[1] = 8'hC2; c_beats[2] = 8'hC3; c_beats[3] = 8'hC4;
        sent = 0;
        a = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            if (a) sent++;
            if (sent >= 2) break;
            drive_port(0, 1'b1, c_beats[sent], 1'b0);
            #1;
            a = req.s_valid[0] & req.s_ready[0];
        end
        check("pre_reset_beat2_en", out_en, 1);
        check("pre_reset_beat2_d", out_d, 8'hC2);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_frame_reset");
        drive_port(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = PORTS - 1;
        idle_run   = 0;
        in_frame   = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        add_frame(0, 2, 0);
        add_frame(2, 2, 0);
        run_round();

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
